// File: rtl/outbuf_drain.sv
// Output-buffer drain: pops PAR_READ-wide words, streams signed elements on valid/ready, pulses done at count.
// Latency: start to first m_valid = 3 cycles; stalls on empty FIFO or m_ready low; ReLU via OUTBUF_DRAIN_RELU_EN.
module outbuf_drain #(
   parameter int DATA_WIDTH = 16,
   parameter int PAR_READ   = 2,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                           clk,
   input  logic                           rstn,
   input  logic                           start,
   input  logic [CNT_WIDTH-1:0]           total_words,
   input  logic                           outbuf_empty,
   output logic                           outbuf_ren,
   input  logic [PAR_READ*DATA_WIDTH-1:0] outbuf_dout,
   output logic                           m_valid,
   input  logic                           m_ready,
   output logic [DATA_WIDTH-1:0]          m_data,
   output logic                           m_last,
   output logic                           busy,
   output logic                           done
);

   localparam int LANE_W = (PAR_READ > 1) ? $clog2(PAR_READ) : 1;
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PAR_READ - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT,
      S_EMIT,
      S_DONE
   } state_t;

   state_t                         state_q;
   logic [CNT_WIDTH-1:0]           remaining_q;
   logic [LANE_W-1:0]              lane_q;
   logic [PAR_READ*DATA_WIDTH-1:0] hold_q;
   logic                           m_valid_q;
   logic                           busy_q;
   logic                           done_q;
   logic [DATA_WIDTH-1:0]          elem;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= S_IDLE;
         remaining_q <= '0;
         lane_q      <= '0;
         hold_q      <= '0;
         m_valid_q   <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  remaining_q <= total_words;
                  busy_q      <= 1'b1;
                  if (total_words == '0) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= S_FETCH;
                  end
               end
            end
            S_FETCH: begin
               if (!outbuf_empty) state_q <= S_WAIT;
            end
            // FIFO has one-cycle read latency: the popped word is on outbuf_dout now.
            S_WAIT: begin
               hold_q    <= outbuf_dout;
               lane_q    <= '0;
               m_valid_q <= 1'b1;
               state_q   <= S_EMIT;
            end
            S_EMIT: begin
               if (m_ready) begin
                  remaining_q <= remaining_q - CNT_WIDTH'(1);
                  if (remaining_q == CNT_WIDTH'(1)) begin
                     m_valid_q <= 1'b0;
                     done_q    <= 1'b1;
                     state_q   <= S_DONE;
                  end else if (lane_q == LAST_LANE) begin
                     m_valid_q <= 1'b0;
                     state_q   <= S_FETCH;
                  end else begin
                     lane_q <= lane_q + LANE_W'(1);
                  end
               end
            end
            S_DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               state_q   <= S_IDLE;
               m_valid_q <= 1'b0;
               busy_q    <= 1'b0;
               done_q    <= 1'b0;
            end
         endcase
      end
   end

   assign outbuf_ren = (state_q == S_FETCH) && !outbuf_empty;
   assign m_valid    = m_valid_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign m_last     = m_valid_q && (remaining_q == CNT_WIDTH'(1));
   assign elem       = hold_q[lane_q*DATA_WIDTH +: DATA_WIDTH];

`ifdef OUTBUF_DRAIN_RELU_EN
   assign m_data = elem[DATA_WIDTH-1] ? '0 : elem;
`else
   assign m_data = elem;
`endif

endmodule

// File: tb/tb_outbuf_drain.sv
// Directed bench for outbuf_drain: FIFO model, handshake monitor, and immediate-assertion checks.
module tb_outbuf_drain;
   localparam int DW = 16;
   localparam int PR = 2;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          rstn, start, outbuf_empty, outbuf_ren;
   logic          m_valid, m_ready, m_last, busy, done;
   logic [CW-1:0] total_words;
   logic [PR*DW-1:0] outbuf_dout = '0;
   logic [DW-1:0] m_data;

   outbuf_drain #(.DATA_WIDTH(DW), .PAR_READ(PR), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rstn(rstn), .start(start), .total_words(total_words),
      .outbuf_empty(outbuf_empty), .outbuf_ren(outbuf_ren), .outbuf_dout(outbuf_dout),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // FIFO model with one-cycle read latency
   logic [PR*DW-1:0] mem [16];
   int wp = 0;
   int rp = 0;
   assign outbuf_empty = (wp == rp);
   always @(posedge clk) if (outbuf_ren) begin
      outbuf_dout <= mem[rp % 16];
      rp <= rp + 1;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input int obs, input int exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   int got_d[$];
   bit got_l[$];
   int rens = 0, dones = 0, stalls = 0, hs_cyc = 0, done_cyc = 0;
   bit prev_stall = 0;
   logic [DW-1:0] prev_d;
   logic prev_l;

   always @(negedge clk) begin
      if (rstn) begin
         if (prev_stall) begin
            chk("stall_vld", int'(m_valid), 1);
            chk("stall_dat", int'(m_data), int'(prev_d));
            chk("stall_last", int'(m_last), int'(prev_l));
         end
         chk("ren_while_empty", int'(outbuf_ren & outbuf_empty), 0);
         if (m_valid && m_ready) begin
            got_d.push_back($signed(m_data));
            got_l.push_back(m_last);
            hs_cyc = cyc;
         end
         if (outbuf_ren) rens++;
         if (done) begin
            dones++;
            done_cyc = cyc;
         end
         if (m_valid && !m_ready) stalls++;
         prev_stall = m_valid && !m_ready;
         prev_d = m_data;
         prev_l = m_last;
      end else begin
         prev_stall = 0;
      end
   end

   function automatic int ex(input int v);
`ifdef OUTBUF_DRAIN_RELU_EN
      return (v < 0) ? 0 : v;
`else
      return v;
`endif
   endfunction

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
      #1;
   endtask

   task automatic push(input int l1, input int l0);
      mem[wp % 16] = {16'(l1), 16'(l0)};
      wp++;
   endtask

   // Called at a drive point; returns just after the accepting edge N.
   task automatic begin_drain(input int n);
      got_d.delete();
      got_l.delete();
      start = 1'b1;
      total_words = CW'(n);
      smp();
      nxt();
      start = 1'b0;
      total_words = CW'(99);
   endtask

   task automatic wait_done(input int budget, input bit tog);
      bit seen = 0;
      for (int i = 0; i < budget && !seen; i++) begin
         nxt();
         if (tog) m_ready = ~m_ready;
         smp();
         if (done) seen = 1;
      end
      chk("done_timeout", int'(seen), 1);
   endtask

   task automatic chk_seq(input string tag, input int exp[4], input int n);
      chk({tag, "_count"}, got_d.size(), n);
      for (int i = 0; i < n; i++) begin
         if (i < got_d.size()) begin
            chk($sformatf("%s_d%0d", tag, i), got_d[i], ex(exp[i]));
            chk($sformatf("%s_last%0d", tag, i), int'(got_l[i]), (i == n - 1) ? 1 : 0);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   int r0, d0, s0;

   initial begin
      rstn = 1'b0;
      start = 1'b0;
      total_words = '0;
      m_ready = 1'b0;
      push(-3, 5);
      push(7, -1);
      smp();
      smp();
      chk("rst_valid", int'(m_valid), 0);
      chk("rst_data", int'(m_data), 0);
      chk("rst_last", int'(m_last), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_ren", int'(outbuf_ren), 0);
      nxt();
      rstn = 1'b1;
      smp();

      // Four elements, ready held high
      nxt();
      m_ready = 1'b1;
      r0 = rens; d0 = dones;
      begin_drain(4);
      smp();
      chk("t1_n1_busy", int'(busy), 1);
      chk("t1_n1_ren", int'(outbuf_ren), 1);
      nxt(); smp();
      chk("t1_n2_ren", int'(outbuf_ren), 0);
      chk("t1_n2_vld", int'(m_valid), 0);
      nxt(); smp();
      chk("t1_n3_vld", int'(m_valid), 1);
      chk("t1_n3_dat", int'($signed(m_data)), ex(5));
      wait_done(50, 0);
      chk_seq("t1", '{5, -3, -1, 7}, 4);
      chk("t1_pops", rens - r0, 2);
      chk("t1_dones", dones - d0, 1);
      chk("t1_done_lat", done_cyc, hs_cyc + 1);
      nxt(); smp();
      chk("t1_done_pulse", int'(done), 0);
      chk("t1_idle", int'(busy), 0);

      // Partial final word
      nxt();
      push(-3, 5);
      push(7, -1);
      r0 = rens;
      begin_drain(3);
      wait_done(50, 0);
      chk_seq("t2", '{5, -3, -1, 0}, 3);
      chk("t2_pops", rens - r0, 2);
      chk("t2_fifo_empty", int'(outbuf_empty), 1);

      // Backpressure: m_ready toggles every cycle
      nxt();
      push(-3, 5);
      push(7, -1);
      r0 = rens; s0 = stalls;
      m_ready = 1'b0;
      begin_drain(4);
      wait_done(100, 1);
      chk_seq("t3", '{5, -3, -1, 7}, 4);
      chk("t3_pops", rens - r0, 2);
      chk("t3_stalled", (stalls - s0 > 0) ? 1 : 0, 1);

      // Empty FIFO stall with an ignored mid-drain start
      nxt();
      m_ready = 1'b1;
      r0 = rens; d0 = dones;
      begin_drain(2);
      for (int i = 0; i < 10; i++) begin
         start = (i == 4);
         total_words = CW'(5);
         smp();
         nxt();
      end
      start = 1'b0;
      chk("t4_stall_pops", rens - r0, 0);
      chk("t4_stall_busy", int'(busy), 1);
      push(9, -8);
      smp();
      chk("t4_ren", int'(outbuf_ren), 1);
      nxt(); smp();
      chk("t4_vld_r1", int'(m_valid), 0);
      nxt(); smp();
      chk("t4_vld_r2", int'(m_valid), 1);
      wait_done(50, 0);
      chk_seq("t4", '{-8, 9, 0, 0}, 2);
      chk("t4_pops", rens - r0, 1);
      chk("t4_dones", dones - d0, 1);

      // Zero count: done at N+1, no pop even with data present
      nxt();
      push(-3, 5);
      push(7, -1);
      r0 = rens;
      begin_drain(0);
      smp();
      chk("t5_done", int'(done), 1);
      chk("t5_ren", int'(outbuf_ren), 0);
      nxt(); smp();
      chk("t5_done_off", int'(done), 0);
      chk("t5_idle", int'(busy), 0);
      chk("t5_pops", rens - r0, 0);

      // Reset during EMIT
      nxt();
      r0 = rens;
      begin_drain(4);
      smp();
      nxt(); smp();
      nxt(); smp();
      chk("t6_emit", int'(m_valid), 1);
      rstn = 1'b0;
      #1;
      chk("t6_rst_vld", int'(m_valid), 0);
      chk("t6_rst_dat", int'(m_data), 0);
      chk("t6_rst_last", int'(m_last), 0);
      chk("t6_rst_busy", int'(busy), 0);
      chk("t6_rst_done", int'(done), 0);
      chk("t6_rst_ren", int'(outbuf_ren), 0);
      nxt();
      rstn = 1'b1;
      smp();
      chk("t6_post_busy", int'(busy), 0);
      chk("t6_pops", rens - r0, 1);

      // Recovery drains the remaining word
      nxt();
      begin_drain(2);
      wait_done(50, 0);
      chk_seq("t7", '{-1, 7, 0, 0}, 2);
      chk("t7_fifo_empty", int'(outbuf_empty), 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/outbuf_drain.md
# outbuf_drain

Host-side reader for the accelerator's output buffer. It pops `PAR_READ`-wide words from the output FIFO through the `outbuf_ren`/`outbuf_empty`/`outbuf_dout` interface. It unpacks each word into single signed elements and streams them out on a valid/ready port until a programmed element count is reached. It then pulses `done`, and the host can start the next tile.

## Interface
Parameters:
- `DATA_WIDTH`, 16, element width; equals the accelerator's psum width.
- `PAR_READ`, 2, elements per FIFO word; equals the accelerator's `outbuf_par_read`.
- `CNT_WIDTH`, 16, width of the element counter.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a drain of `total_words` elements; sampled only in IDLE.
- `total_words`  in  CNT_WIDTH  element count; latched on an accepted `start`.
- `outbuf_empty`  in  1  output FIFO empty flag.
- `outbuf_ren`  out  1  FIFO pop strobe.
- `outbuf_dout`  in  PAR_READ*DATA_WIDTH  FIFO read data, signed; lane 0 = bits [DATA_WIDTH-1:0].
- `m_valid`  out  1  element available.
- `m_ready`  in  1  downstream accepts element.
- `m_data`  out  DATA_WIDTH  signed element.
- `m_last`  out  1  high with the final element of the drain.
- `busy`  out  1  high in any state except IDLE.
- `done`  out  1  one-cycle pulse at drain completion.

## Operation
- Reset value of every output is 0. The FSM is in IDLE, and the counter, lane index and holding register are cleared.
- States: IDLE, FETCH, WAIT, EMIT, DONE.
- IDLE
  - On `start`, latch `remaining = total_words`.
  - If `total_words == 0`, go to DONE; otherwise go to FETCH.
- FETCH
  - `outbuf_ren = !outbuf_empty`, combinational.
  - When `outbuf_ren` is 1, go to WAIT. Otherwise stay in FETCH; the block waits indefinitely on an empty FIFO.
- WAIT
  - FIFO data becomes valid this cycle; capture `outbuf_dout` into the holding register.
  - Set `lane = 0` and go to EMIT.
- EMIT
  - `m_valid = 1` and `m_data = holding[lane]`.
  - `m_last = (remaining == 1)`.
  - On `m_valid && m_ready`, decrement `remaining`, then:
    - if `remaining` was 1, go to DONE;
    - else if `lane == PAR_READ-1`, go to FETCH;
    - else increment `lane`.
- DONE
  - Assert `done` for one cycle, then go to IDLE.
- Partial final word: when `total_words` is not a multiple of `PAR_READ`, the unused upper lanes of the last word are discarded. The FIFO is not popped again.
- Output stability: `m_data`/`m_last` are held stable while `m_valid && !m_ready`. `m_valid` never drops without a handshake.
- `start` outside IDLE is ignored; `total_words` changes are ignored after latching.
- Exactly one `outbuf_ren` pulse per fetched word. `outbuf_ren` is never asserted while `outbuf_empty` is 1.
- `rstn` low mid-drain returns to IDLE asynchronously:
  - held elements are lost;
  - `done` is not asserted;
  - `outbuf_ren` drops immediately.

## Timing
- Start latency: `start` is accepted at edge N. FETCH occupies cycle N+1, with `outbuf_ren` high if the FIFO is non-empty. WAIT occupies N+2. `m_valid` rises in cycle N+3.
- FIFO read latency is one cycle: data for a pop in cycle k is sampled at the end of cycle k+1.
- Throughput with `m_ready` held high is `PAR_READ` elements per `PAR_READ`+2 cycles.
- Completion: the last handshake at edge M gives `done` in cycle M+1, IDLE in cycle M+2, and a new `start` accepted at the edge ending cycle M+2.
- `total_words == 0`: `done` in cycle N+1 and no FIFO pop.

## Configuration
- `OUTBUF_DRAIN_RELU_EN` defined: each element is ReLU'd as it leaves.
  - A negative `holding[lane]` is driven as 0 on `m_data`; non-negative values pass unchanged.
  - The stage is combinational on the EMIT output and adds no latency.
- `OUTBUF_DRAIN_RELU_EN` undefined: `m_data` is the raw signed element.

## Test plan
- Four elements, FIFO preloaded:
  - Setup: `PAR_READ=2`, `total_words=4`, words {lane1=-3, lane0=5} and {lane1=7, lane0=-1}, `m_ready=1`.
  - Required: `m_data` sequence 5, -3, -1, 7; `m_last` only on 7; exactly 2 `outbuf_ren` pulses; `done` one cycle after the last handshake.
- Partial final word:
  - Setup: `total_words=3`, same FIFO contents.
  - Required: outputs 5, -3, -1 with `m_last` on -1; 2 pops; lane value 7 discarded; FIFO left empty.
- Backpressure:
  - Setup: toggle `m_ready` 0/1 every cycle.
  - Required: `m_data` is stable while stalled, no element is duplicated or dropped, and order matches the first case.
- Empty FIFO stall:
  - Setup: `start` with `outbuf_empty=1` for 10 cycles, then one word is written.
  - Required: `outbuf_ren` stays 0 during the stall; `m_valid` rises 2 cycles after the first `outbuf_ren`.
- Zero count and ignored restart:
  - Setup: `total_words=0`; then `start` re-pulsed during a drain.
  - Required: `done` in cycle N+1 with no pop; the mid-drain `start` has no effect.
- Reset mid-drain and ReLU:
  - Reset: drive `rstn` low during EMIT; all outputs go to 0 immediately and the block is IDLE after release.
  - ReLU: with `OUTBUF_DRAIN_RELU_EN` defined, the first case emits 5, 0, 0, 7.
